// File: rtl/hr_bridge_fifo_pkg.sv
// Shared types and defaults for the hierarchical-ring bridge transfer FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hr_bridge_fifo_pkg;

    // Flit width matches the bridge control word.
    localparam int CONTROL_W = 144;

    typedef logic [CONTROL_W-1:0] flit_t;

    // The bridge treats an all-zero flit as "no flit present".
    localparam flit_t INVALID_FLIT = '0;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_SLACK = 1;

    // Ceiling log2, used to size the FIFO pointers from DEPTH.
    function automatic int hr_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hr_bridge_fifo.sv
// Transfer buffer between ring stages of the hierarchical-ring bridge.
// Latency: zero-latency read; a flit written at edge N is on data_o after N, poppable at N+1.
// Backpressure: bfull_o asserts at count >= DEPTH-SLACK; overflowing writes drop and set ovf_o.
//
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   enQ_i/data_i  enqueue strobe and flit from the upstream ring side
//   deQ_i         dequeue strobe from the bridge
//   data_o        head flit (all-zero when empty)
//   bfull_o       back-pressure to the bridge
//   empty_o       occupancy is zero
//   count_o       occupancy 0..DEPTH
//   ovf_o, unf_o  sticky overflow / underflow errors, cleared only by reset
module hr_bridge_fifo
    import hr_bridge_fifo_pkg::*;
#(
    parameter int DW    = CONTROL_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = hr_clog2(DEPTH),
    parameter int SLACK = DEF_SLACK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enQ_i,
    input  logic [DW-1:0] data_i,
    input  logic          deQ_i,
    output logic [DW-1:0] data_o,
    output logic          bfull_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BFULL_THR = (AW+1)'(DEPTH - SLACK);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic empty;
    logic do_wr;
    logic do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A write into a full FIFO is still legal when a pop frees the head slot
    // on the same edge. A pop from an empty FIFO never happens, even if a
    // write lands on that edge: there is no write-through path.
    assign do_wr = enQ_i && (!full || deQ_i);
    assign do_rd = deQ_i && !empty;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst && do_wr) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (enQ_i && full && !deQ_i) begin
                ovf_o <= 1'b1;
            end
            if (deQ_i && empty) begin
                unf_o <= 1'b1;
            end
        end
    end

    assign data_o  = empty ? '0 : mem[rd_ptr];
    assign bfull_o = (count >= BFULL_THR);
    assign empty_o = empty;
    assign count_o = count;

endmodule

// File: tb/tb_hr_bridge_fifo.sv
// Directed self-checking bench for hr_bridge_fifo (DEPTH=4, SLACK=1).
// Latency: inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Backpressure: exercises bfull, overflow drop, full push+pop and underflow paths.
module tb_hr_bridge_fifo;
    import hr_bridge_fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        enQ_i;
    flit_t       data_i;
    logic        deQ_i;
    flit_t       data_o;
    logic        bfull_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        ovf_o;
    logic        unf_o;

    int n_chk;
    int n_pass;

    hr_bridge_fifo #(
        .DW    (CONTROL_W),
        .DEPTH (4),
        .AW    (2),
        .SLACK (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enQ_i   (enQ_i),
        .data_i  (data_i),
        .deQ_i   (deQ_i),
        .data_o  (data_o),
        .bfull_o (bfull_o),
        .empty_o (empty_o),
        .count_o (count_o),
        .ovf_o   (ovf_o),
        .unf_o   (unf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CONTROL_W-1:0] got,
                       input logic [CONTROL_W-1:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input flit_t d, input logic de);
        enQ_i  = en;
        data_i = d;
        deQ_i  = de;
        tick();
        enQ_i  = 1'b0;
        deQ_i  = 1'b0;
        data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    flit_t f_t2, f_a, f_b, f_c, f_d, f_e, f_f, f_n, f_y, f_z;
    flit_t pairs [8];
    flit_t heads [8];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        enQ_i  = 1'b0;
        deQ_i  = 1'b0;
        data_i = '0;

        f_t2 = 144'h0123456789abcdef0123456789abcdef185f;
        f_a  = 144'h0a0a;
        f_b  = 144'h0b0b;
        f_c  = 144'h0c0c;
        f_d  = 144'h0d0d;
        f_e  = 144'h0e0e;
        f_f  = 144'h0f0f;
        f_n  = 144'h5555_0000_0000_0000_0000_0000_0000_0000_0001;
        f_y  = 144'h7777;
        f_z  = 144'h9999;
        for (int i = 0; i < 8; i++) begin
            pairs[i] = flit_t'(144'h100 + i);
        end

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_data",  data_o,  '0);
        chk("rst_empty", empty_o, 1);
        chk("rst_bfull", bfull_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ovf",   ovf_o,   0);
        chk("rst_unf",   unf_o,   0);

        // 2: single flit in and out
        drive(1'b1, f_t2, 1'b0);
        chk("t2_data",  data_o,  f_t2);
        chk("t2_count", count_o, 1);
        chk("t2_empty", empty_o, 0);
        drive(1'b0, '0, 1'b1);
        chk("t2_pop_data",  data_o,  '0);
        chk("t2_pop_count", count_o, 0);
        chk("t2_pop_empty", empty_o, 1);

        // 3: fill, slack threshold, overflow drop, drain order
        drive(1'b1, f_a, 1'b0);
        drive(1'b1, f_b, 1'b0);
        chk("t3_cnt2",   count_o, 2);
        chk("t3_bfull2", bfull_o, 0);
        drive(1'b1, f_c, 1'b0);
        chk("t3_cnt3",   count_o, 3);
        chk("t3_bfull3", bfull_o, 1);
        drive(1'b1, f_d, 1'b0);
        chk("t3_cnt4", count_o, 4);
        chk("t3_ovf4", ovf_o,   0);
        drive(1'b1, f_e, 1'b0);
        chk("t3_cnt_drop", count_o, 4);
        chk("t3_ovf_drop", ovf_o,   1);
        chk("t3_pop_a", data_o, f_a);
        drive(1'b0, '0, 1'b1);
        chk("t3_pop_b", data_o, f_b);
        drive(1'b0, '0, 1'b1);
        chk("t3_pop_c", data_o, f_c);
        drive(1'b0, '0, 1'b1);
        chk("t3_pop_d", data_o, f_d);
        drive(1'b0, '0, 1'b1);
        chk("t3_drained_cnt",  count_o, 0);
        chk("t3_drained_data", data_o,  '0);
        chk("t3_ovf_sticky",   ovf_o,   1);

        // 4: full push+pop, then wrap with 8 further pairs
        do_reset();
        chk("t4_rst_ovf", ovf_o, 0);
        drive(1'b1, f_a, 1'b0);
        drive(1'b1, f_b, 1'b0);
        drive(1'b1, f_c, 1'b0);
        drive(1'b1, f_d, 1'b0);
        drive(1'b1, f_f, 1'b1);
        chk("t4_cnt",  count_o, 4);
        chk("t4_head", data_o,  f_b);
        chk("t4_ovf",  ovf_o,   0);
        heads[0] = f_b;
        heads[1] = f_c;
        heads[2] = f_d;
        heads[3] = f_f;
        for (int i = 4; i < 8; i++) begin
            heads[i] = pairs[i-4];
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_wrap_head%0d", i), data_o, heads[i]);
            drive(1'b1, pairs[i], 1'b1);
        end
        chk("t4_wrap_cnt", count_o, 4);
        chk("t4_wrap_ovf", ovf_o,   0);
        for (int i = 4; i < 8; i++) begin
            chk($sformatf("t4_drain%0d", i), data_o, pairs[i]);
            drive(1'b0, '0, 1'b1);
        end
        chk("t4_drain_cnt", count_o, 0);

        // 5: underflow, then simultaneous enQ+deQ on empty
        drive(1'b0, '0, 1'b1);
        chk("t5_unf", unf_o,   1);
        chk("t5_cnt", count_o, 0);
        drive(1'b1, f_n, 1'b1);
        chk("t5_both_cnt",  count_o, 1);
        chk("t5_both_data", data_o,  f_n);

        // 6: reset mid-operation with a strobe present
        drive(1'b1, f_a, 1'b0);
        drive(1'b1, f_b, 1'b0);
        chk("t6_pre_cnt", count_o, 3);
        rst    = 1'b0;
        enQ_i  = 1'b1;
        data_i = f_z;
        tick();
        rst    = 1'b1;
        enQ_i  = 1'b0;
        data_i = '0;
        chk("t6_cnt",   count_o, 0);
        chk("t6_data",  data_o,  '0);
        chk("t6_empty", empty_o, 1);
        chk("t6_ovf",   ovf_o,   0);
        chk("t6_unf",   unf_o,   0);
        drive(1'b1, f_y, 1'b0);
        chk("t6_post_data", data_o,  f_y);
        chk("t6_post_cnt",  count_o, 1);
        drive(1'b0, '0, 1'b1);
        chk("t6_post_pop_cnt",  count_o, 0);
        chk("t6_post_pop_data", data_o,  '0);
        chk("t6_post_unf",      unf_o,   0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
